// File: rtl/fifo_a_pkg.sv
// rtl/fifo_a_pkg.sv - shared FIFO_A datapath types and constants
package fifo_a_pkg;

    // Word width shared with the upstream parallel-in/serial-out shifter.
    localparam int WORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Width of the deserializer bit counter for a given word width.
    function automatic int deser_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial input and parallel output handshake bundle
interface sipo_deser_if
    import fifo_a_pkg::*;
#(
    parameter int WIDTH = WORD_W
);
    logic             sin_vld;
    logic             sin;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;

    // Environment side: supplies the bit stream and consumes words.
    modport master (
        output sin_vld, sin, sof, dout_rdy,
        input  dout, dout_vld
    );

    // Deserializer side.
    modport slave (
        input  sin_vld, sin, sof, dout_rdy,
        output dout, dout_vld
    );
endinterface

// File: rtl/sipo_out_reg.sv
// rtl/sipo_out_reg.sv - one-entry valid/ready holding register with overrun detect
module sipo_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rdy,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data,
    output logic             vld,
    output logic             overrun
);

    logic drain;
    logic room;

    assign drain = vld && rdy;
    // A slot is free when empty or being emptied this very cycle.
    assign room  = !vld || drain;

    // Load wins over drain so a simultaneous transfer+load keeps vld high with no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (load && room) begin
            data <= load_data;
            vld  <= 1'b1;
        end else if (drain) begin
            vld  <= 1'b0;
        end
    end

    // Sticky overrun: a word arrived with nowhere to go; a new event beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (load && !room) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - framed serial-in/parallel-out deserializer
module sipo_deser
    import fifo_a_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sipo_deser_if.slave bus,
    output logic       overrun,
    output logic       frame_err,
    input  logic       err_clr,
    output logic       busy
);

    localparam int             CNT_W = deser_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    deser_state_t     state;
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh_next;
    logic             start;
    logic             accept;
    logic             complete;

    // Insert one bit into a word image in the configured arrival order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
        if (LSB_FIRST) begin
            return {b, base[WIDTH-1:1]};
        end else begin
            return {base[WIDTH-2:0], b};
        end
    endfunction

    assign start    = bus.sin_vld && bus.sof;
    assign accept   = bus.sin_vld && !bus.sof && (state == SHIFT);
    assign complete = accept && (cnt == LAST);

    // Next shift image; a start of frame begins from a clean word so stale bits never leak.
    always_comb begin
        sh_next = shift_in(sh, bus.sin);
        if (start) begin
            sh_next = shift_in('0, bus.sin);
        end
    end

    // Framing FSM: collects bits, restarts on sof, returns to IDLE on the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (start) begin
                sh    <= sh_next;
                cnt   <= CNT_W'(1);
                state <= SHIFT;
                busy  <= 1'b1;
            end else if (accept) begin
                sh <= sh_next;
                if (complete) begin
                    cnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            if (start && (state == SHIFT)) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (sh_next),
        .rdy       (bus.dout_rdy),
        .err_clr   (err_clr),
        .data      (bus.dout),
        .vld       (bus.dout_vld),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser in both bit orders
module tb_sipo_deser;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sin_vld = 1'b0;
    logic sin = 1'b0;
    logic sof = 1'b0;
    logic dout_rdy = 1'b1;
    logic err_clr = 1'b0;

    int vectors = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sipo_deser_if #(.WIDTH(W)) if_l ();
    sipo_deser_if #(.WIDTH(W)) if_m ();

    assign if_l.sin_vld = sin_vld;
    assign if_l.sin = sin;
    assign if_l.sof = sof;
    assign if_l.dout_rdy = dout_rdy;
    assign if_m.sin_vld = sin_vld;
    assign if_m.sin = sin;
    assign if_m.sof = sof;
    assign if_m.dout_rdy = dout_rdy;

    logic ovr_l, fe_l, busy_l, ovr_m, fe_m, busy_m;

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .bus(if_l),
        .overrun(ovr_l), .frame_err(fe_l), .err_clr(err_clr), .busy(busy_l)
    );

    sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .bus(if_m),
        .overrun(ovr_m), .frame_err(fe_m), .err_clr(err_clr), .busy(busy_m)
    );

    logic [W-1:0] a_dout [2];
    logic         a_vld  [2];
    logic         a_ovr  [2];
    logic         a_fe   [2];
    logic         a_busy [2];
    assign a_dout[0] = if_l.dout;
    assign a_dout[1] = if_m.dout;
    assign a_vld[0]  = if_l.dout_vld;
    assign a_vld[1]  = if_m.dout_vld;
    assign a_ovr[0]  = ovr_l;
    assign a_ovr[1]  = ovr_m;
    assign a_fe[0]   = fe_l;
    assign a_fe[1]   = fe_m;
    assign a_busy[0] = busy_l;
    assign a_busy[1] = busy_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: frames are tracked as a bit position count and an accumulated
    // word; bit i of a frame lands at position i (LSB first) or W-1-i (MSB first).
    bit           m_in_frame [2];
    int           m_nbits    [2];
    logic [W-1:0] m_acc      [2];
    logic [W-1:0] m_dout     [2];
    bit           m_vld      [2];
    bit           m_ovr      [2];
    bit           m_fe       [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_in_frame[k] = 0; m_nbits[k] = 0; m_acc[k] = '0;
                m_dout[k] = '0; m_vld[k] = 0; m_ovr[k] = 0; m_fe[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit comp, drain, fe_ev, ovr_ev;
                int pos;
                comp = 0; fe_ev = 0; ovr_ev = 0;
                if (sin_vld) begin
                    if (sof) begin
                        if (m_in_frame[k]) fe_ev = 1;
                        m_in_frame[k] = 1;
                        m_nbits[k] = 0;
                        m_acc[k] = '0;
                    end
                    if (m_in_frame[k]) begin
                        pos = (k == 0) ? m_nbits[k] : (W - 1 - m_nbits[k]);
                        if (sin) m_acc[k] = m_acc[k] | (W'(1) << pos);
                        m_nbits[k] = m_nbits[k] + 1;
                        if (m_nbits[k] == W) begin
                            comp = 1;
                            m_in_frame[k] = 0;
                        end
                    end
                end
                drain = m_vld[k] && dout_rdy;
                if (comp) begin
                    if (!m_vld[k] || drain) begin
                        m_dout[k] = m_acc[k];
                        m_vld[k] = 1;
                    end else begin
                        ovr_ev = 1;
                    end
                end else if (drain) begin
                    m_vld[k] = 0;
                end
                if (ovr_ev) m_ovr[k] = 1; else if (err_clr) m_ovr[k] = 0;
                if (fe_ev) m_fe[k] = 1; else if (err_clr) m_fe[k] = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cyc%0d_vld", k), 32'(a_vld[k]), 32'(m_vld[k]));
            chk($sformatf("cyc%0d_busy", k), 32'(a_busy[k]), 32'(m_in_frame[k]));
            chk($sformatf("cyc%0d_ovr", k), 32'(a_ovr[k]), 32'(m_ovr[k]));
            chk($sformatf("cyc%0d_fe", k), 32'(a_fe[k]), 32'(m_fe[k]));
            if (m_vld[k]) chk($sformatf("cyc%0d_dout", k), 32'(a_dout[k]), 32'(m_dout[k]));
        end
    end

    // Words actually handed over by the LSB-first instance.
    logic [W-1:0] xfer_log [$];
    always @(posedge clk) begin
        if (rst && if_l.dout_vld && dout_rdy) xfer_log.push_back(if_l.dout);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic b, input logic s);
        sin_vld = 1'b1; sin = b; sof = s;
        step();
        sin_vld = 1'b0; sof = 1'b0;
    endtask

    // Sends w in stream order w[0] first, with sof on the first bit.
    task automatic send_word(input logic [W-1:0] w, input int gap, input bit chk_busy,
                             input bit rdy_last, input bit chk_vld);
        for (int i = 0; i < W; i++) begin
            sin_vld = 1'b1; sin = w[i]; sof = (i == 0);
            if (rdy_last && i == W - 1) dout_rdy = 1'b1;
            step();
            sin_vld = 1'b0; sof = 1'b0;
            if (chk_vld) chk("vld_held", 32'(if_l.dout_vld), 32'd1);
            if (i < W - 1) begin
                if (chk_busy) chk("busy_mid", 32'(busy_l), 32'd1);
                for (int g = 0; g < gap; g++) begin
                    step();
                    if (chk_busy) chk("busy_gap", 32'(busy_l), 32'd1);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step();
        chk("rst_dout", 32'(if_l.dout), 32'h0);
        chk("rst_vld", 32'(if_l.dout_vld), 32'd0);
        chk("rst_busy", 32'(busy_l), 32'd0);
        chk("rst_flags", {30'd0, ovr_l, fe_l}, 32'd0);
        rst = 1'b1;
        step();

        // Basic word, bits 0,1,0,1,...
        dout_rdy = 1'b1;
        send_word(8'hAA, 0, 0, 0, 0);
        chk("basic_dout", 32'(if_l.dout), 32'hAA);
        chk("basic_vld", 32'(if_l.dout_vld), 32'd1);
        chk("basic_msb_dout", 32'(if_m.dout), 32'h55);
        step();
        chk("basic_vld_drop", 32'(if_l.dout_vld), 32'd0);
        chk("basic_flags", {30'd0, ovr_l, fe_l}, 32'd0);

        // Gapped strobes
        send_word(8'h3C, 2, 1, 0, 0);
        chk("gap_dout", 32'(if_l.dout), 32'h3C);
        chk("gap_busy_end", 32'(busy_l), 32'd0);
        step();

        // Backpressure and overrun
        dout_rdy = 1'b0;
        send_word(8'h55, 0, 0, 0, 0);
        chk("bp_first", 32'(if_l.dout), 32'h55);
        send_word(8'h0F, 0, 0, 0, 0);
        chk("bp_dout_kept", 32'(if_l.dout), 32'h55);
        chk("bp_overrun", 32'(ovr_l), 32'd1);
        dout_rdy = 1'b1;
        step();
        chk("bp_drained", 32'(if_l.dout_vld), 32'd0);
        chk("bp_ovr_sticky", 32'(ovr_l), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("bp_ovr_clr", 32'(ovr_l), 32'd0);

        // Simultaneous drain and load
        dout_rdy = 1'b0;
        send_word(8'h12, 0, 0, 0, 0);
        chk("sim_hold", 32'(if_l.dout), 32'h12);
        send_word(8'h34, 0, 0, 1, 1);
        chk("sim_dout", 32'(if_l.dout), 32'h34);
        chk("sim_vld", 32'(if_l.dout_vld), 32'd1);
        chk("sim_no_ovr", 32'(ovr_l), 32'd0);
        step();
        chk("sim_drain", 32'(if_l.dout_vld), 32'd0);

        // Resync: sof, 3 bits, then a full framed word
        xfer_log.delete();
        send_raw(1'b1, 1'b1);
        send_raw(1'b0, 1'b0);
        send_raw(1'b1, 1'b0);
        send_word(8'hC3, 0, 0, 0, 0);
        repeat (2) step();
        chk("rs_frame_err", 32'(fe_l), 32'd1);
        chk("rs_count", 32'(xfer_log.size()), 32'd1);
        if (xfer_log.size() > 0) chk("rs_word", 32'(xfer_log[0]), 32'hC3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("rs_fe_clr", 32'(fe_l), 32'd0);

        // Reset mid-word, then bits must wait for a fresh sof
        send_raw(1'b1, 1'b1);
        send_raw(1'b1, 1'b0);
        send_raw(1'b0, 1'b0);
        send_raw(1'b1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_dout_l", 32'(if_l.dout), 32'h0);
        chk("mid_rst_dout_m", 32'(if_m.dout), 32'h0);
        chk("mid_rst_busy", {30'd0, busy_l, busy_m}, 32'd0);
        chk("mid_rst_vld", {30'd0, if_l.dout_vld, if_m.dout_vld}, 32'd0);
        step();
        rst = 1'b1;
        step();
        send_raw(1'b1, 1'b0);
        send_raw(1'b1, 1'b0);
        chk("no_sof_idle", 32'(busy_m), 32'd0);
        send_word(8'h81, 0, 0, 0, 0);
        chk("msb_81", 32'(if_m.dout), 32'h81);
        chk("lsb_81", 32'(if_l.dout), 32'h81);
        send_word(8'h01, 0, 0, 0, 0);
        chk("msb_80", 32'(if_m.dout), 32'h80);
        chk("lsb_01", 32'(if_l.dout), 32'h01);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in/parallel-out deserializer that sits directly downstream of the team's parallel-in/serial-out shifter in the FIFO_A datapath.
- Collects a framed, LSB-first bit stream back into WIDTH-bit words.
- Holds each completed word in a one-entry output register with a valid/ready handshake toward the receive FIFO.
- Reports sticky overrun and framing errors.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
LSB_FIRST, 1, 1 = first received bit lands in dout[0]; 0 = first received bit lands in dout[WIDTH-1].

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
sin_vld  input  1  serial bit strobe; sin and sof are sampled only when this is 1
sin  input  1  serial data bit
sof  input  1  start of frame, qualified by sin_vld, marks the first bit of a word
dout  output  WIDTH  assembled word, stable while dout_vld=1
dout_vld  output  1  output register holds an unconsumed word
dout_rdy  input  1  consumer accepts; transfer occurs when dout_vld && dout_rdy
overrun  output  1  sticky: a word completed while the output register was full and not draining
frame_err  output  1  sticky: sof arrived mid-word
err_clr  input  1  synchronous clear of overrun and frame_err
busy  output  1  1 while in SHIFT state

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; shift register and bit counter are cleared.
  - dout=0, dout_vld=0, overrun=0, frame_err=0, busy=0.
- The bit counter is $clog2(WIDTH) bits wide and counts accepted bits of the current word.
- Shift rule on each accepted bit:
  - LSB_FIRST=1: sh <= {sin, sh[WIDTH-1:1]}.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], sin}.
- IDLE:
  - sin_vld && sof: shift in the bit, cnt=1, go to SHIFT.
  - sin_vld && !sof: the bit is ignored.
- SHIFT:
  - Each sin_vld && !sof: shift in the bit, cnt++.
  - When the bit with cnt==WIDTH-1 is accepted, the word is complete: go to IDLE, cnt=0.
  - sin_vld=0 cycles are gaps: no state change and no timeout.
- Resync: sin_vld && sof in SHIFT sets frame_err=1, discards the partial word, restarts with this bit as bit 0 (cnt=1) and stays in SHIFT.
- Word completion, evaluated with the output register state in the same cycle:
  - If dout_vld=0, or dout_vld && dout_rdy: next cycle dout = the completed word and dout_vld=1.
  - Otherwise the new word is dropped, dout keeps the old word, and overrun=1.
- Output latency: dout_vld rises on the clock edge after the final bit's strobe, so one cycle later the word is visible; no combinational sin-to-dout path.
- Handshake:
  - dout_vld && dout_rdy with no completion that cycle clears dout_vld next cycle.
  - Transfer and completion in the same cycle: dout_vld stays 1 and dout is replaced; no bubble, no overrun.
  - dout_rdy while dout_vld=0 has no effect.
- err_clr clears both sticky flags.
  - If err_clr coincides with a new error event, the flag stays 1 (set wins).
- Reset mid-word discards the partial word. The next word requires a fresh sof.

Decomposition:
- Shared package fifo_a_pkg:
  - typedef enum for the deserializer state {IDLE, SHIFT}.
  - Localparam DESER_CNT_W = $clog2(WIDTH), or a function computing it.
  - Default word width constant WORD_W=8, shared with the upstream serializer.
- One sub-module is natural: sipo_out_reg. It is the one-entry valid/ready holding register with load, drain, simultaneous load+drain and overrun-detect logic. It is reusable by other FIFO_A stages.
- Shift/count/FSM logic stays in sipo_deser.

Test Plan:
- Basic word: WIDTH=8, LSB_FIRST=1, dout_rdy=1; sof on the first strobe; bits 0,1,0,1,0,1,0,1 on consecutive cycles -> one cycle after the 8th strobe, dout=8'hAA and dout_vld=1; dout_vld=0 the following cycle; no flags set.
- Gapped strobes: send 8'h3C with sin_vld=0 for 2 cycles between each bit -> dout=8'h3C; busy=1 throughout the word and 0 after.
- Backpressure/overrun: dout_rdy=0; send 8'h55 then 8'h0F -> dout stays 8'h55 and overrun=1; raise dout_rdy -> 8'h55 is consumed and dout_vld=0; err_clr -> overrun=0.
- Simultaneous drain+load: hold 8'h12 with dout_rdy=0; assert dout_rdy exactly on the cycle the 8th bit of 8'h34 is strobed -> dout=8'h34, dout_vld continuously 1, overrun=0.
- Resync: sof, 3 bits, then sof again with 8 bits of 8'hC3 -> frame_err=1 and the single output word is 8'hC3.
- Reset mid-word plus MSB-first: LSB_FIRST=0; drop rst after 4 bits -> all outputs 0; then send bits 1,0,0,0,0,0,0,1 -> dout=8'h81.
